sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Owns the external 512 KB SRAM pins and shares them between two requesters.
- Port A is the host memory cycle path and has priority. Port B is the background requester (loader/debug DMA).
- Sequences each SRAM access with a programmable strobe width.
- Performs read-modify-write for byte writes, because the SRAM has no byte-lane pins.

Parameters:
ACCESS_CYCLES, 2, clocks that CS/OE or CS/WE are held low per SRAM access (legal range 1..15)
ADDR_W, 18, SRAM word-address width
FAIR_LIMIT, 4, consecutive A grants allowed while B waits (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
i_a_req  in  1  port A request, level; held until o_a_ack
i_a_we  in  1  port A 1=write 0=read
i_a_addr  in  ADDR_W  port A word address
i_a_wdata  in  16  port A write data
i_a_be  in  2  port A byte enables, [1]=bits 15:8, [0]=bits 7:0
o_a_ack  out  1  port A one-cycle completion pulse
o_a_rdata  out  16  port A read data, valid with o_a_ack and held until the next A read
i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be, o_b_ack, o_b_rdata  same widths and meaning for port B
o_sram_address  out  ADDR_W  SRAM address
o_sram_data  out  16  SRAM write data
o_sram_data_out_en  out  1  1=FPGA drives SRAM data pins
i_sram_data  in  16  SRAM read data
RAMCS, RAMOE, RAMWE  out  1 each  SRAM strobes, active low
o_busy  out  1  high in any state except IDLE
o_state  out  3  current state, for debug

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; RAMCS=RAMOE=RAMWE=1; o_sram_data_out_en=0.
  - acks=0; rdata=0; address and data registers=0; fairness counter=0.
  - Asserting reset mid-access deasserts all strobes immediately and drops the access with no ack. After release, the requester is expected to still be asserting req, and the access is re-granted.
- States (encodings): IDLE=0, READ=1, RMW_READ=2, WRITE=3, RECOVER=4.
- IDLE arbitration:
  - If i_a_req=1, grant A.
  - Else if i_b_req=1, grant B.
  - Else stay in IDLE.
- On grant, latch owner, we, addr, wdata and be into registers. All SRAM outputs are driven only from these registers.
- Next state on grant:
  - Read goes to READ.
  - Write with be=2'b11 goes to WRITE.
  - Write with be=2'b01 or 2'b10 goes to RMW_READ.
  - Write with be=2'b00 goes directly to RECOVER (acked, no SRAM cycle).
- READ / RMW_READ:
  - RAMCS=0, RAMOE=0, out_en=0 for ACCESS_CYCLES clocks, counted by a 4-bit down-counter.
  - i_sram_data is sampled on the last clock.
  - READ then goes to RECOVER with the sample loaded into the owner's rdata.
  - RMW_READ merges the unenabled byte(s) from the sample into the write register, then goes to WRITE.
- WRITE:
  - out_en=1 on every WRITE cycle.
  - RAMCS=0 on every WRITE cycle.
  - RAMWE=0 on all WRITE cycles except the last, where RAMWE=1 (data hold).
  - With ACCESS_CYCLES=1, RAMWE=0 for that single cycle, and data hold comes from RECOVER.
  - Then goes to RECOVER.
- RECOVER:
  - All strobes high; out_en stays 1 only if entered from WRITE.
  - Owner's ack=1 for exactly this cycle.
  - Always goes to IDLE.
- Requester rule: req must be low in the cycle after ack. Requests are not sampled outside IDLE. Changing fields while req is high and unacked is illegal; the latched values are used.
- Latency from req high in IDLE to ack high:
  - read: ACCESS_CYCLES+1
  - full write: ACCESS_CYCLES+1
  - byte write: 2*ACCESS_CYCLES+1
- Minimum spacing between back-to-back grants: one IDLE cycle.
- Simultaneous A and B requests: A wins. B stays pending with no ack.
- Without the optional feature, B can starve indefinitely under continuous A traffic.

Optional Feature:
- Macro: SRAM_ARB_FAIRNESS_EN.
- When defined:
  - A 3-bit counter increments on each A grant made while i_b_req=1.
  - The counter clears on any B grant.
  - When the counter equals FAIR_LIMIT and i_b_req=1, the next IDLE arbitration grants B even if i_a_req=1.
- When undefined: strict A priority; counter logic is absent.

Test Plan:
- ACCESS_CYCLES=2. A read of addr 0x00123, SRAM model returns 0x8040 -> RAMCS/RAMOE low for 2 cycles; o_a_ack 3 cycles after req; o_a_rdata=0x8040.
- A full write of 0x1234 to 0x00200 (be=11) -> RAMWE low for exactly 1 cycle; out_en high through RECOVER; model holds 0x1234; ack 3 cycles after req.
- Model 0x00200=0xAABB, A writes wdata=0x00CC with be=01 -> RMW read, then write 0xAACC; ack 5 cycles after req.
- A and B requests raised in the same cycle -> A is served first; B is acked in the following access; B is never acked in the same cycle as A.
- reset_n pulsed low during WRITE -> all strobes high and out_en=0 asynchronously; no ack; held request is completed after release.
- With SRAM_ARB_FAIRNESS_EN and FAIR_LIMIT=4, A and B held high continuously -> grant order A,A,A,A,B repeating. Without the macro, B is never granted.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an external 16-bit async SRAM with programmable strobe width and byte-write RMW.
// Optional B anti-starvation limit is enabled by defining SRAM_ARB_FAIRNESS_EN.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_W        = 18,
  parameter int unsigned FAIR_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [15:0]       i_a_wdata,
  input  logic [1:0]        i_a_be,
  output logic              o_a_ack,
  output logic [15:0]       o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [15:0]       i_b_wdata,
  input  logic [1:0]        i_b_be,
  output logic              o_b_ack,
  output logic [15:0]       o_b_rdata,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic [15:0]       o_sram_data,
  output logic              o_sram_data_out_en,
  input  logic [15:0]       i_sram_data,
  output logic              RAMCS,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              o_busy,
  output logic [2:0]        o_state
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic SINGLE_CYCLE = (ACCESS_CYCLES == 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RECOVER  = 3'd4
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_b_q, owner_b_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic              cs_q, cs_d, oe_q, oe_d, we_q, we_d, den_q, den_d, busy_q, busy_d;
  logic              grant_b_c;
  req_t              sel_c;

`ifdef SRAM_ARB_FAIRNESS_EN
  logic [2:0] fair_q, fair_d;
  assign grant_b_c = i_b_req & (~i_a_req | (fair_q == 3'(FAIR_LIMIT)));
`else
  logic [2:0] unused_fair_limit;
  assign unused_fair_limit = 3'(FAIR_LIMIT);
  assign grant_b_c = i_b_req & ~i_a_req;
`endif

  assign sel_c = grant_b_c ? '{we: i_b_we, addr: i_b_addr, wdata: i_b_wdata, be: i_b_be}
                           : '{we: i_a_we, addr: i_a_addr, wdata: i_a_wdata, be: i_a_be};

  // Next-state, datapath and registered-output decode for the state being entered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_b_d = owner_b_q;
    req_d     = req_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifdef SRAM_ARB_FAIRNESS_EN
    fair_d    = fair_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_a_req || i_b_req) begin
          owner_b_d = grant_b_c;
          req_d     = sel_c;
          cnt_d     = CNT_LOAD;
          if (!sel_c.we)              state_d = READ;
          else if (sel_c.be == 2'b11) state_d = WRITE;
          else if (sel_c.be == 2'b00) state_d = RECOVER;
          else                        state_d = RMW_READ;
`ifdef SRAM_ARB_FAIRNESS_EN
          if (grant_b_c)    fair_d = 3'd0;
          else if (i_b_req) fair_d = fair_q + 3'd1;
`endif
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          if (owner_b_q) b_rdata_d = i_sram_data;
          else           a_rdata_d = i_sram_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RMW_READ: begin
        if (cnt_q == '0) begin
          // Keep enabled lanes from the requester, fill the rest from the SRAM
          req_d.wdata = {req_q.be[1] ? req_q.wdata[15:8] : i_sram_data[15:8],
                         req_q.be[0] ? req_q.wdata[7:0]  : i_sram_data[7:0]};
          state_d = WRITE;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt_q == '0) state_d = RECOVER;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_d    = ~((state_d == READ) || (state_d == RMW_READ) || (state_d == WRITE));
    oe_d    = ~((state_d == READ) || (state_d == RMW_READ));
    // Last WRITE cycle releases WE for data hold unless the strobe is a single cycle
    we_d    = ~((state_d == WRITE) && ((cnt_d != '0) || SINGLE_CYCLE));
    den_d   = (state_d == WRITE) || ((state_d == RECOVER) && (state_q == WRITE));
    a_ack_d = (state_d == RECOVER) && !owner_b_d;
    b_ack_d = (state_d == RECOVER) && owner_b_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_b_q <= 1'b0;
      req_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      cs_q      <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      den_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SRAM_ARB_FAIRNESS_EN
      fair_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_b_q <= owner_b_d;
      req_q     <= req_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      cs_q      <= cs_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      den_q     <= den_d;
      busy_q    <= busy_d;
`ifdef SRAM_ARB_FAIRNESS_EN
      fair_q    <= fair_d;
`endif
    end
  end

  assign o_a_ack            = a_ack_q;
  assign o_b_ack            = b_ack_q;
  assign o_a_rdata          = a_rdata_q;
  assign o_b_rdata          = b_rdata_q;
  assign o_sram_address     = req_q.addr;
  assign o_sram_data        = req_q.wdata;
  assign o_sram_data_out_en = den_q;
  assign RAMCS              = cs_q;
  assign RAMOE              = oe_q;
  assign RAMWE              = we_q;
  assign o_busy             = busy_q;
  assign o_state            = state_q;

endmodule
